// File: rtl/qspi_flash_responder.sv
// qspi_flash_responder: read-only W25Q-style QSPI flash target (0x03/0x6B/0x9F).
// Define QSPI_RESP_QIO_EN to also accept 0xEB (quad I/O fast read).
module qspi_flash_responder #(
  parameter int          ADDR_W   = 24,
  parameter int          DUMMY_6B = 8,
  parameter logic [23:0] JEDEC_ID = 24'hEF4018
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              qspi_ck_i,
  input  logic              qspi_cs_i,
  input  logic [3:0]        qspi_io_i,
  output logic [3:0]        qspi_io_o,
  output logic [3:0]        qspi_io_oe_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              busy_o,
  output logic              cmd_err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_IGN
  } state_t;

  localparam logic [4:0] DLAST = 5'(DUMMY_6B - 1);

  state_t              r_state, w_next;
  logic [2:0]          r_ck_s;
  logic [1:0]          r_cs_s;
  logic [3:0]          r_io_s0, r_io_s1;
  logic [22:0]         r_sh;
  logic [4:0]          r_cnt;
  logic [2:0]          r_bpos;
  logic [1:0]          r_idx;
  logic                r_quad, r_qio, r_id;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_rd, r_rd_d, r_err;
  logic [7:0]          r_pre, r_byte;
  logic [3:0]          r_io;

  logic                w_csn, w_rise, w_fall;
  logic [7:0]          w_cmd;
  logic                w_cmd_ok, w_cmd_quad, w_cmd_qio, w_cmd_id;
  logic [23:0]         w_ashift;
  logic                w_alast, w_dlast, w_blast;
  logic [7:0]          w_id, w_src, w_cur;
  logic                w_bit;
  logic [3:0]          w_nib;

  assign w_csn    = r_cs_s[1];
  assign w_rise   = r_ck_s[1] & ~r_ck_s[2] & ~w_csn;
  assign w_fall   = ~r_ck_s[1] & r_ck_s[2] & ~w_csn;
  assign w_cmd    = {r_sh[6:0], r_io_s1[0]};
  assign w_ashift = r_qio ? {r_sh[19:0], r_io_s1}
                          : {r_sh, r_io_s1[0]};
  assign w_alast  = r_cnt == (r_qio ? 5'd5 : 5'd23);
  assign w_dlast  = r_cnt == (r_qio ? 5'd5 : DLAST);
  assign w_blast  = r_quad ? (r_bpos == 3'd1) : (r_bpos == 3'd7);
  assign w_src    = r_id ? w_id : r_pre;
  assign w_cur    = (r_bpos == 3'd0) ? w_src : r_byte;
  assign w_bit    = w_cur[3'd7 - r_bpos];
  assign w_nib    = r_bpos[0] ? w_cur[3:0] : w_cur[7:4];

  // Pad drivers are cut as soon as synced CSn rises, ahead of the FSM.
  assign qspi_io_o    = r_io;
  assign qspi_io_oe_o = (r_state == S_DATA && !w_csn)
                      ? (r_quad ? 4'b1111 : 4'b0010) : 4'b0000;
  assign busy_o       = !w_csn && (r_state == S_CMD ||
                        r_state == S_ADDR || r_state == S_DUMMY ||
                        r_state == S_DATA);
  assign mem_addr_o   = r_addr;
  assign mem_rd_o     = r_rd;
  assign cmd_err_o    = r_err;

  // Pin synchronisers; third ck flop feeds the edge detectors.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ck_s  <= 3'b000;
      r_cs_s  <= 2'b11;
      r_io_s0 <= 4'h0;
      r_io_s1 <= 4'h0;
    end else begin
      r_ck_s  <= {r_ck_s[1:0], qspi_ck_i};
      r_cs_s  <= {r_cs_s[0], qspi_cs_i};
      r_io_s0 <= qspi_io_i;
      r_io_s1 <= r_io_s0;
    end
  end

  // Opcode decode of the byte completing on this rise.
  always_comb begin
    w_cmd_ok   = 1'b0;
    w_cmd_quad = 1'b0;
    w_cmd_qio  = 1'b0;
    w_cmd_id   = 1'b0;
    case (w_cmd)
      8'h03: w_cmd_ok = 1'b1;
      8'h6B: begin
        w_cmd_ok   = 1'b1;
        w_cmd_quad = 1'b1;
      end
      8'h9F: begin
        w_cmd_ok = 1'b1;
        w_cmd_id = 1'b1;
      end
`ifdef QSPI_RESP_QIO_EN
      8'hEB: begin
        w_cmd_ok   = 1'b1;
        w_cmd_quad = 1'b1;
        w_cmd_qio  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // JEDEC ID byte selector; zeros after the three ID bytes.
  always_comb begin
    unique case (r_idx)
      2'd0:    w_id = JEDEC_ID[23:16];
      2'd1:    w_id = JEDEC_ID[15:8];
      2'd2:    w_id = JEDEC_ID[7:0];
      default: w_id = 8'h00;
    endcase
  end

  // Next-state logic; CSn high forces IDLE from anywhere.
  always_comb begin
    w_next = r_state;
    if (w_csn) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  w_next = S_CMD;
        S_CMD:
          if (w_rise && r_cnt == 5'd7)
            w_next = !w_cmd_ok ? S_IGN
                   : w_cmd_id ? S_DATA : S_ADDR;
        S_ADDR:
          if (w_rise && w_alast)
            w_next = r_quad ? S_DUMMY : S_DATA;
        S_DUMMY:
          if (w_rise && w_dlast) w_next = S_DATA;
        default: ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Shifters, counters, memory prefetch and output bit placement.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sh   <= '0;
      r_cnt  <= '0;
      r_bpos <= '0;
      r_idx  <= '0;
      r_quad <= 1'b0;
      r_qio  <= 1'b0;
      r_id   <= 1'b0;
      r_addr <= '0;
      r_rd   <= 1'b0;
      r_rd_d <= 1'b0;
      r_err  <= 1'b0;
      r_pre  <= '0;
      r_byte <= '0;
      r_io   <= '0;
    end else begin
      r_rd   <= 1'b0;
      r_err  <= 1'b0;
      r_rd_d <= r_rd;
      if (r_rd_d) r_pre <= mem_rdata_i;
      if (w_csn || r_state == S_IDLE) begin
        r_cnt  <= '0;
        r_bpos <= '0;
        r_idx  <= '0;
        r_io   <= '0;
      end else begin
        unique case (r_state)
          S_CMD:
            if (w_rise) begin
              r_sh  <= {r_sh[21:0], r_io_s1[0]};
              r_cnt <= r_cnt + 5'd1;
              if (r_cnt == 5'd7) begin
                r_cnt  <= '0;
                r_quad <= w_cmd_quad;
                r_qio  <= w_cmd_qio;
                r_id   <= w_cmd_id;
                r_err  <= ~w_cmd_ok;
              end
            end
          S_ADDR:
            if (w_rise) begin
              r_sh  <= w_ashift[22:0];
              r_cnt <= r_cnt + 5'd1;
              if (w_alast) begin
                r_cnt  <= '0;
                r_addr <= w_ashift[ADDR_W-1:0];
                r_rd   <= 1'b1;
              end
            end
          S_DUMMY:
            if (w_rise) begin
              r_cnt <= w_dlast ? 5'd0 : r_cnt + 5'd1;
            end
          S_DATA:
            if (w_fall) begin
              r_io <= r_quad ? w_nib : {2'b00, w_bit, 1'b0};
              if (r_bpos == 3'd0) r_byte <= w_src;
              if (w_blast) begin
                r_bpos <= '0;
                if (r_id) begin
                  if (r_idx != 2'd3) r_idx <= r_idx + 2'd1;
                end else begin
                  r_addr <= r_addr + ADDR_W'(1);
                  r_rd   <= 1'b1;
                end
              end else begin
                r_bpos <= r_bpos + 3'd1;
              end
            end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/qspi_flash_responder.md
Name: qspi_flash_responder

Overview:
- QSPI target that emulates the read side of a W25Q-class serial flash.
- Serves byte reads from a backing memory port, so the core's QSPI controller can be exercised against synthesizable logic (FPGA or emulation) instead of the behavioural flash model.
- Sits on the flash side of qspi_itf: CSn, CLK and IO[3:0] from the core, tristate enables for IO back to the pads.
- All QSPI pins are oversampled in the single clk_i domain.

Parameters:
- ADDR_W, 24, byte address width of the backing memory; addresses wrap modulo 2^ADDR_W.
- DUMMY_6B, 8, dummy SCK cycles for opcode 0x6B.
- JEDEC_ID, 24'hEF4018, value returned by opcode 0x9F, MSB first.

Ports:
- clk_i  in  1  system clock; must be at least 4x the SCK frequency.
- rst_i  in  1  reset.
- qspi_ck_i  in  1  SCK from the initiator.
- qspi_cs_i  in  1  CSn, active-low.
- qspi_io_i  in  4  IO[3:0] pad inputs.
- qspi_io_o  out  4  IO[3:0] pad outputs.
- qspi_io_oe_o  out  4  per-pin output enable.
- mem_addr_o  out  ADDR_W  backing memory byte address.
- mem_rd_o  out  1  read strobe.
- mem_rdata_i  in  8  read data, valid one clk_i cycle after mem_rd_o.
- busy_o  out  1  high while CSn is asserted and the transaction is not being ignored.
- cmd_err_o  out  1  one-cycle pulse when an unsupported opcode is received.

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is asynchronous and active-high.
- Reset values: io_o=0, io_oe_o=0, mem_addr_o=0, mem_rd_o=0, busy_o=0, cmd_err_o=0, FSM=IDLE.
- Input synchronisation: 2-flop synchronisers on ck, cs and io[3:0]. A third ck flop gives rise/fall detection.
- Edge usage: sample inputs on SCK rise; update outputs on SCK fall. Output settles at most 4 clk_i cycles after the physical SCK fall.
- Bit order: MSB first. In quad mode the high nibble goes first.
- FSM IDLE: wait for synced cs low, then go to CMD with the bit counter cleared.
- FSM CMD: shift 8 bits from IO0. On the 8th rise, decode:
  - 0x03 -> ADDR, single-lane read.
  - 0x6B -> ADDR, quad-output read.
  - 0x9F -> DATA, ID source.
  - anything else -> IGNORE, with cmd_err_o pulsed one cycle.
- FSM ADDR: 24 rises on IO0. The low ADDR_W bits are kept. On the last rise, issue mem_rd_o for that address.
  - 0x03 -> DATA.
  - 0x6B -> DUMMY.
- FSM DUMMY: count DUMMY_6B rises, then go to DATA. All oe stay 0.
- FSM DATA, single lane: drive IO1 only (oe=4'b0010), one bit per fall.
- FSM DATA, quad: oe=4'b1111, one nibble per fall.
- Byte pipeline: the first bit/nibble of a byte is driven on the fall after the last addr/dummy rise. When the last bit of a byte is placed, latch the prefetched byte, increment the address (wrap ADDR_W) and issue the next mem_rd_o. Reads stream indefinitely.
- 0x9F data: sends JEDEC_ID bytes, then 0x00 forever. No memory access.
- FSM IGNORE: no drive, no memory access until cs high.
- CS deassert in any state: FSM -> IDLE, oe=0 and busy_o=0 within 3 clk_i cycles of the physical CSn rise. A partial byte is discarded and counters are cleared.
- Async reset mid-transaction: immediate oe=0 and IDLE. The next cs low starts a fresh command.
- SCK edges while cs is high are ignored.
- busy_o is 1 in CMD, ADDR, DUMMY and DATA.

Optional Feature:
- Macro: QSPI_RESP_QIO_EN.
- Defined: opcode 0xEB (Fast Read Quad I/O) is supported.
  - 24-bit address taken as 6 nibbles on IO[3:0].
  - 2 mode clocks, value ignored.
  - 4 dummy clocks.
  - Then quad DATA, as for 0x6B.
  - oe=0 until DATA.
- Undefined: 0xEB is treated as an unsupported opcode: IGNORE state, cmd_err_o pulse.

Test Plan:
- 0x03 read: memory[0x000100..]=0xA5,0x3C; cs low, 0x03, addr 0x000100, 16 SCK -> IO1 carries 0xA5 then 0x3C, oe=4'b0010, mem_addr_o steps 0x100 then 0x101.
- 0x6B read: 0x6B, addr 0x000010, 8 dummy, 4 SCK -> nibbles 0xD,0xE,0xA,0xD for memory bytes 0xDE,0xAD. oe=0 through dummy, 4'b1111 in data.
- JEDEC ID: 0x9F, then 32 SCK on IO1 -> 0xEF,0x40,0x18,0x00. mem_rd_o never asserted.
- Wrap and bad opcode:
  - ADDR_W=24, 0x03 at 0xFFFFFF, 16 SCK -> bytes from 0xFFFFFF then 0x000000.
  - Opcode 0x02 -> cmd_err_o one pulse, oe stays 0 until cs high.
- Abort and reset: raise cs after 5 data bits -> oe=0 within 3 clk_i cycles, and the next 0x03 transaction returns correct data. Assert rst_i mid-ADDR -> oe=0 immediately, busy_o=0.
- With QSPI_RESP_QIO_EN: 0xEB, addr nibbles 0,0,0,2,0,0, 2 mode + 4 dummy, 2 SCK -> byte memory[0x000200] on IO[3:0]. Without the macro: cmd_err_o pulses.
